// File: rtl/wide_add_stream.sv
// wide_add_stream: narrow-stream front/back end for a 100-bit adder.
// Loads A then B beat-wise, captures Sum/Cout once, streams the result out.
module wide_add_stream #(
    parameter int BEAT_W    = 10,
    parameter int NUM_BEATS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic              out_cout,
    output logic [99:0]       add_A,
    output logic [99:0]       add_B,
    output logic              add_Cin,
    input  logic [99:0]       add_Sum,
    input  logic              add_Cout
);

    if (BEAT_W * NUM_BEATS != 100) begin : g_width_chk
        $error("BEAT_W*NUM_BEATS must equal 100");
    end

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        SEND
    } state_t;

    localparam logic [3:0] LAST = 4'(NUM_BEATS - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [99:0] result;
    logic        cout_q;
    logic        last_beat;
    logic        in_fire;
    logic        out_fire;
    int          base;

    assign last_beat = (cnt == LAST);
    assign base      = int'(cnt) * BEAT_W;

    // Handshake flags are pure state decodes, never from in_valid/out_ready.
    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid = (state == SEND);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Result beat selection; everything reads 0 outside SEND.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        out_cout = 1'b0;
        if (state == SEND) begin
            out_data = result[base +: BEAT_W];
            out_last = last_beat;
            out_cout = last_beat ? cout_q : 1'b0;
        end
    end

    // Sequencer: operand loading, single compute capture, result streaming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= LOAD_A;
            cnt     <= '0;
            add_A   <= '0;
            add_B   <= '0;
            add_Cin <= 1'b0;
            result  <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state)
                LOAD_A: begin
                    if (in_fire) begin
                        add_A[base +: BEAT_W] <= in_data;
                        if (cnt == 4'd0) begin
                            add_Cin <= in_cin;
                        end
                        if (last_beat) begin
                            state <= LOAD_B;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_fire) begin
                        add_B[base +: BEAT_W] <= in_data;
                        if (last_beat) begin
                            state <= COMPUTE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                COMPUTE: begin
                    result <= add_Sum;
                    cout_q <= add_Cout;
                    state  <= SEND;
                    cnt    <= '0;
                end
                SEND: begin
                    if (out_fire) begin
                        if (last_beat) begin
                            state <= LOAD_A;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= LOAD_A;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
